mult_share_arbiter: RTL

//  Shares one sequential shift-add 8x8 multiplier among NUM_REQ requesters (neuron MAC lanes of the MLP).

---
 rtl/mult_share_arbiter_pkg.sv | 10 +
 rtl/mult_share_arbiter_if.sv | 35 +++
 rtl/mult_share_arbiter_rr_pick.sv | 35 +++
 rtl/mult_share_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mult_share_arbiter_pkg.sv
// Shared types for the multiplier-sharing arbiter: FSM state encoding and width defaults.
package mult_arb_pkg;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam int DefNumReq = 4;
  localparam int DefDataW  = 8;
  localparam int DefProdW  = 2 * DefDataW;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Lane-side and multiplier-side signals of the arbiter; slave = arbiter, master = environment.
interface mult_share_arbiter_if
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = DefNumReq,
  parameter int DATA_W  = DefDataW,
  parameter int PROD_W  = DefProdW,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [PROD_W-1:0]         result;
  logic [IDX_W-1:0]          result_idx;
  logic                      busy;
  logic                      mul_start;
  logic [DATA_W-1:0]         mul_a;
  logic [DATA_W-1:0]         mul_b;
  logic [PROD_W-1:0]         mul_product;
  logic                      mul_ready;

  modport slave (
    input  req, req_a, req_b, mul_product, mul_ready,
    output gnt, done, result, result_idx, busy, mul_start, mul_a, mul_b
  );

  modport master (
    output req, req_a, req_b, mul_product, mul_ready,
    input  gnt, done, result, result_idx, busy, mul_start, mul_a, mul_b
  );

endinterface

// File: rtl/mult_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting lane at or after i_ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  int               w_sum;
  logic [IDX_W-1:0] w_lane;

  // Scan from the farthest offset down so the lane nearest the pointer is written last and wins.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_sum  = 0;
    w_lane = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum  = (int'(i_ptr) + NUM_REQ - 1 - k) % NUM_REQ;
      w_lane = IDX_W'(w_sum);
      if (i_req[w_lane]) begin
        o_gnt         = '0;
        o_gnt[w_lane] = 1'b1;
        o_idx         = w_lane;
        o_any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one sequential multiplier among NUM_REQ lanes: grant, issue, wait for ready, return product.
// MULT_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = DefNumReq,
  parameter int DATA_W  = DefDataW,
  parameter int PROD_W  = DefProdW,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic                 clk,
  input logic                 rst_n,
  mult_share_arbiter_if.slave bus
);

  state_e             r_state, w_state_d;
  logic [IDX_W-1:0]   r_ptr, w_ptr_d;
  logic [IDX_W-1:0]   r_idx, w_idx_d;
  logic [IDX_W-1:0]   r_result_idx, w_result_idx_d;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_d;
  logic [NUM_REQ-1:0] r_done, w_done_d;
  logic [PROD_W-1:0]  r_result, w_result_d;
  logic [DATA_W-1:0]  r_mul_a, w_mul_a_d;
  logic [DATA_W-1:0]  r_mul_b, w_mul_b_d;
  logic               r_mul_start, w_mul_start_d;
  logic               r_wait_first, w_wait_first_d;
  logic               r_busy;

  logic [NUM_REQ-1:0] w_pick_gnt;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_any;

  // In fixed-priority builds the pointer never leaves 0, so the picker degenerates to lowest-index.
  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  always_comb begin
    w_state_d      = r_state;
    w_ptr_d        = r_ptr;
    w_idx_d        = r_idx;
    w_result_idx_d = r_result_idx;
    w_gnt_d        = '0;
    w_done_d       = '0;
    w_result_d     = r_result;
    w_mul_a_d      = r_mul_a;
    w_mul_b_d      = r_mul_b;
    w_mul_start_d  = 1'b0;
    w_wait_first_d = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_pick_any) begin
          w_state_d     = StIssue;
          w_gnt_d       = w_pick_gnt;
          w_mul_start_d = 1'b1;
          w_idx_d       = w_pick_idx;
          w_mul_a_d     = bus.req_a[w_pick_idx*DATA_W +: DATA_W];
          w_mul_b_d     = bus.req_b[w_pick_idx*DATA_W +: DATA_W];
`ifndef MULT_ARB_FIXED_PRIO_EN
          w_ptr_d = (w_pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
`endif
        end
      end
      StIssue: begin
        w_state_d      = StWait;
        w_wait_first_d = 1'b1;
      end
      StWait: begin
        // Ready seen in the first WAIT cycle may still belong to the previous job.
        if (!r_wait_first && bus.mul_ready) begin
          w_state_d       = StDone;
          w_result_d      = bus.mul_product;
          w_result_idx_d  = r_idx;
          w_done_d[r_idx] = 1'b1;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_ptr        <= '0;
      r_idx        <= '0;
      r_result_idx <= '0;
      r_gnt        <= '0;
      r_done       <= '0;
      r_result     <= '0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_mul_start  <= 1'b0;
      r_wait_first <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_ptr        <= w_ptr_d;
      r_idx        <= w_idx_d;
      r_result_idx <= w_result_idx_d;
      r_gnt        <= w_gnt_d;
      r_done       <= w_done_d;
      r_result     <= w_result_d;
      r_mul_a      <= w_mul_a_d;
      r_mul_b      <= w_mul_b_d;
      r_mul_start  <= w_mul_start_d;
      r_wait_first <= w_wait_first_d;
      r_busy       <= (w_state_d != StIdle);
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.done       = r_done;
  assign bus.result     = r_result;
  assign bus.result_idx = r_result_idx;
  assign bus.busy       = r_busy;
  assign bus.mul_start  = r_mul_start;
  assign bus.mul_a      = r_mul_a;
  assign bus.mul_b      = r_mul_b;

endmodule
